// File: rtl/mac_array_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mac_array_ctrl_pkg
//   Shared definitions for the MAC tile array sequencer:
//     - state_t : sequencer state encoding
//     - INST_*  : 2-bit inst codes driven onto the array west edge
//     - MODE_*  : dataflow mode constants (weight-stationary / output-stationary)
//     - max_int : elaboration-time helper for sizing the phase counter
// -----------------------------------------------------------------------------
package mac_array_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        KLOAD = 3'd2,
        KGAP  = 3'd3,
        EXEC  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    // inst_w bit0 = kernel load, bit1 = execute
    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mac_array_ctrl.sv
// -----------------------------------------------------------------------------
// mac_array_ctrl
//   Sequencer for a row x col MAC tile array. Each operation clears the array,
//   streams the kernel from SRAM (WS mode only), streams the activations,
//   waits for the array to drain and then pulses done.
//
//   The SRAM read port has one cycle of latency, so inst_w is the read phase
//   delayed by one cycle: each inst_w beat lines up with the SRAM word it
//   refers to.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   start      begin an operation (sampled only in IDLE)
//   mode_in    0 = WS, 1 = OS (sampled with start)
//   len        number of execute vectors (sampled with start)
//   w_base     kernel base address (sampled with start)
//   x_base     activation base address (sampled with start)
//   abort      cancel the running operation, back to IDLE without done
//   busy       high in every non-IDLE state
//   done       one-cycle completion pulse
//   mode       latched mode to the array, updated on entry to CLR
//   array_rst  reset to the MAC tiles (high for the CLR cycle)
//   inst_w     inst to the array west edge (01 kernel load, 10 execute)
//   rd_en      SRAM read enable
//   rd_addr    SRAM read address (base + phase counter, wraps freely)
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode_in,
    input  logic [len_bw-1:0]  len,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               mode,
    output logic               array_rst,
    output logic [1:0]         inst_w,
    output logic               rd_en,
    output logic [addr_bw-1:0] rd_addr
);

    // Counter must hold both the longest execute phase and the drain length.
    localparam int cnt_bw    = max_int(len_bw, $clog2(row + col + 1));
    localparam int drain_len = row + col;

    typedef logic [cnt_bw-1:0]  cnt_t;
    typedef logic [addr_bw-1:0] addr_t;

    state_t state;
    state_t next_state;
    cnt_t   cnt;
    cnt_t   next_cnt;

    // Operation parameters captured when start is accepted.
    logic [len_bw-1:0] len_q;
    addr_t             w_base_q;
    addr_t             x_base_q;

    logic accept;

    // Next-cycle values of the registered outputs.
    logic       busy_nxt;
    logic       done_nxt;
    logic       array_rst_nxt;
    logic [1:0] inst_w_nxt;
    logic       rd_en_nxt;
    addr_t      rd_addr_nxt;

    // abort outranks start, so a simultaneous pair leaves the block idle.
    assign accept = (state == IDLE) && start && !abort;

    // -------------------------------------------------------------------------
    // Next-state, phase counter and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves it unassigned; a missing default would infer a latch.
        next_state    = state;
        next_cnt      = cnt + cnt_t'(1);
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        array_rst_nxt = 1'b0;
        inst_w_nxt    = INST_IDLE;
        rd_en_nxt     = 1'b0;
        rd_addr_nxt   = '0;

        unique case (state)
            IDLE: begin
                next_cnt = '0;
                if (accept) begin
                    next_state = CLR;
                end
            end

            CLR: begin
                next_cnt = '0;
                if (mode == MODE_WS) begin
                    next_state = KLOAD;
                end else if (len_q == '0) begin
                    next_state = DRAIN;
                end else begin
                    next_state = EXEC;
                end
            end

            KLOAD: begin
                if (cnt == cnt_t'(row - 1)) begin
                    next_state = KGAP;
                    next_cnt   = '0;
                end
            end

            // One idle read slot so the last kernel word reaches the array
            // before the first activation read.
            KGAP: begin
                next_cnt   = '0;
                next_state = (len_q == '0) ? DRAIN : EXEC;
            end

            EXEC: begin
                if (cnt + cnt_t'(1) == cnt_t'(len_q)) begin
                    next_state = DRAIN;
                    next_cnt   = '0;
                end
            end

            DRAIN: begin
                if (cnt == cnt_t'(drain_len - 1)) begin
                    next_state = DONE;
                    next_cnt   = '0;
                end
            end

            DONE: begin
                next_state = IDLE;
                next_cnt   = '0;
            end

            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase

        if (abort && (state != IDLE)) begin
            next_state = IDLE;
            next_cnt   = '0;
        end

        // Outputs are registered, so they are decoded from the state the
        // block is about to enter.
        busy_nxt      = (next_state != IDLE);
        done_nxt      = (next_state == DONE);
        array_rst_nxt = (next_state == CLR);

        if (next_state == KLOAD) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = w_base_q + addr_t'(next_cnt);
        end else if (next_state == EXEC) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = x_base_q + addr_t'(next_cnt);
        end

        // inst_w follows the read issued in the current cycle, i.e. the data
        // that the SRAM returns on the next cycle.
        if (state == KLOAD) begin
            inst_w_nxt = INST_KLOAD;
        end else if (state == EXEC) begin
            inst_w_nxt = INST_EXEC;
        end

        // Returning to IDLE (abort or normal exit) silences the west edge.
        if (next_state == IDLE) begin
            inst_w_nxt = INST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // State, counter, captured parameters and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode      <= MODE_WS;
            array_rst <= 1'b0;
            inst_w    <= INST_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            array_rst <= array_rst_nxt;
            inst_w    <= inst_w_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;

            // mode changes only on the edge into CLR and then holds,
            // including through the following IDLE period.
            if (accept) begin
                mode     <= mode_in;
                len_q    <= len;
                w_base_q <= w_base;
                x_base_q <= x_base;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_array_ctrl
//   Self-checking bench for mac_array_ctrl. Expected per-cycle outputs come
//   from a schedule of SRAM reads (none / kernel / activation) built from the
//   operation's parameters; inst_w is that schedule shifted by one cycle.
// -----------------------------------------------------------------------------
module tb_mac_array_ctrl;

    localparam int ROW        = 8;
    localparam int COL        = 8;
    localparam int ABW        = 11;
    localparam int LBW        = 8;
    localparam int ADDR_SPACE = 1 << ABW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           mode_in;
    logic [LBW-1:0] len;
    logic [ABW-1:0] w_base;
    logic [ABW-1:0] x_base;
    logic           abort;
    logic           busy;
    logic           done;
    logic           mode;
    logic           array_rst;
    logic [1:0]     inst_w;
    logic           rd_en;
    logic [ABW-1:0] rd_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    mac_array_ctrl #(
        .row     (ROW),
        .col     (COL),
        .addr_bw (ABW),
        .len_bw  (LBW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode_in   (mode_in),
        .len       (len),
        .w_base    (w_base),
        .x_base    (x_base),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mode      (mode),
        .array_rst (array_rst),
        .inst_w    (inst_w),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_exp(input logic b, input logic d, input logic m,
                                             input logic ar, input logic [1:0] iw,
                                             input logic re, input logic [ABW-1:0] ra);
        return {14'd0, b, d, m, ar, iw, re, ra};
    endfunction

    // rd_addr is a don't-care while rd_en is low.
    function automatic logic [31:0] dut_vec();
        return pack_exp(busy, done, mode, array_rst, inst_w, rd_en, rd_en ? rd_addr : '0);
    endfunction

    function automatic logic [31:0] dut_raw();
        return pack_exp(busy, done, mode, array_rst, inst_w, rd_en, rd_addr);
    endfunction

    // Reference: list the read issued in each busy cycle, then derive outputs.
    task automatic build_trace(input logic m, input int l, input int wb, input int xb);
        int kind[$];
        int addr[$];
        int n;
        exp_q.delete();
        kind.push_back(0); addr.push_back(0);                 // clear
        if (m == 1'b0) begin
            for (int k = 0; k < ROW; k++) begin
                kind.push_back(1); addr.push_back((wb + k) % ADDR_SPACE);
            end
            kind.push_back(0); addr.push_back(0);             // gap
        end
        for (int k = 0; k < l; k++) begin
            kind.push_back(2); addr.push_back((xb + k) % ADDR_SPACE);
        end
        for (int k = 0; k < ROW + COL; k++) begin
            kind.push_back(0); addr.push_back(0);             // drain
        end
        kind.push_back(0); addr.push_back(0);                 // done
        n = kind.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pack_exp(1'b1, (i == n - 1), m, (i == 0),
                                     (i == 0) ? 2'b00 : 2'(kind[i-1]),
                                     (kind[i] != 0), ABW'(addr[i])));
        end
    endtask

    // Runs one operation from a negedge. kill_kind: 0 none, 1 abort, 2 reset,
    // applied during visible cycle kill_at. Returns on a negedge.
    task automatic run_op(input string tag, input logic m, input int l, input int wb,
                          input int xb, input int kill_at, input int kill_kind,
                          input bit hold, output int nb, output int n01, output int n10);
        int n;
        build_trace(m, l, wb, xb);
        n   = exp_q.size();
        nb  = 0;
        n01 = 0;
        n10 = 0;
        mode_in = m;
        len     = LBW'(l);
        w_base  = ABW'(wb);
        x_base  = ABW'(xb);
        start   = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s cyc%0d", tag, i), dut_vec(), exp_q[i]);
            nb += int'(busy);
            if (inst_w == 2'b01) n01++;
            if (inst_w == 2'b10) n10++;
            if (i == kill_at) begin
                if (kill_kind == 1) abort = 1'b1;
                else reset = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                reset = 1'b0;
                if (kill_kind == 1)
                    check($sformatf("%s after abort", tag), dut_vec(),
                          pack_exp(1'b0, 1'b0, m, 1'b0, 2'b00, 1'b0, '0));
                else
                    check($sformatf("%s after reset", tag), dut_raw(), 32'd0);
                return;
            end
            @(negedge clk);
        end
        check($sformatf("%s idle", tag), dut_vec(),
              pack_exp(1'b0, 1'b0, m, 1'b0, 2'b00, 1'b0, '0));
    endtask

    typedef struct packed {
        logic m;
        int   l;
        int   wb;
        int   xb;
        int   cyc;   // busy cycles
        int   n01;   // kernel-load beats on inst_w
        int   n10;   // execute beats on inst_w
    } vec_t;

    vec_t tbl[5];

    initial begin
        int nb, a, b, n, kill, kk;
        logic m;
        int l, wb, xb, pulses;

        reset = 1'b1; start = 1'b0; abort = 1'b0; mode_in = 1'b0;
        len = '0; w_base = '0; x_base = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", dut_raw(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", dut_raw(), 32'd0);

        // Cycle counts: CLR + (WS: 8 load + gap) + len + 16 drain + DONE.
        tbl[0] = '{1'b0, 4, 'h010, 'h100, 31, 8, 4};
        tbl[1] = '{1'b1, 3, 'h000, 'h234, 21, 0, 3};
        tbl[2] = '{1'b0, 0, 'h3F0, 'h000, 27, 8, 0};
        tbl[3] = '{1'b1, 4, 'h000, 'h7FE, 22, 0, 4};
        tbl[4] = '{1'b1, 0, 'h000, 'h000, 18, 0, 0};
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].l, tbl[i].wb, tbl[i].xb,
                   -1, 0, 1'b0, nb, a, b);
            check($sformatf("tbl%0d busy cycles", i), nb, tbl[i].cyc);
            check($sformatf("tbl%0d kload beats", i), a, tbl[i].n01);
            check($sformatf("tbl%0d exec beats", i), b, tbl[i].n10);
        end

        // Abort in EXEC at k=2: index = 1 + 8 + 1 + 2.
        run_op("abort exec", 1'b0, 4, 'h010, 'h100, 12, 1, 1'b0, nb, a, b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no done after abort", {30'd0, busy, done}, 32'd0);
        end
        run_op("post abort op", 1'b0, 4, 'h010, 'h100, -1, 0, 1'b0, nb, a, b);
        check("post abort busy cycles", nb, 31);

        // abort and start together in IDLE: stays idle, mode not updated.
        mode_in = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort beats start", dut_vec(), pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0));
        @(negedge clk);
        check("still idle", dut_vec(), pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0));

        // Reset during DRAIN of an OS op: index 1 + 3 + 5.
        run_op("reset drain", 1'b1, 3, 0, 'h200, 9, 2, 1'b0, nb, a, b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no done after reset", dut_raw(), 32'd0);
        end

        // start held high: one op, then the next begins right after IDLE.
        run_op("held start", 1'b1, 2, 0, 'h055, -1, 0, 1'b1, nb, a, b);
        check("held start busy cycles", nb, 20);
        @(negedge clk);
        check("second op clr", dut_vec(), pack_exp(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, '0));
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pulses += int'(done);
        end
        check("second op done pulses", pulses, 1);
        check("second op idle", {31'd0, busy}, 32'd0);

        // Randomized operations with occasional abort / reset.
        for (int r = 0; r < 30; r++) begin
            m    = 1'($urandom_range(0, 1));
            l    = int'($urandom_range(0, 12));
            wb   = int'($urandom_range(0, ADDR_SPACE - 1));
            xb   = int'($urandom_range(0, ADDR_SPACE - 1));
            n    = 1 + ((m == 1'b0) ? ROW + 1 : 0) + l + ROW + COL + 1;
            kill = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            kk   = int'($urandom_range(1, 2));
            run_op($sformatf("rnd%0d", r), m, l, wb, xb, kill, kk, 1'b0, nb, a, b);
            if (kill < 0) check($sformatf("rnd%0d exec beats", r), b, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
